// File: rtl/dmem_io_if.sv
// Data-port bundle between the single-cycle core and its data memory responder,
// including the transmit FIFO drain handshake.
interface dmem_io_if;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic        memwrite;
    logic        membyteread;
    logic [31:0] readdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output addr, writedata, memwrite, membyteread, tx_ready,
        input  readdata, tx_data, tx_valid
    );

    modport slave (
        input  addr, writedata, memwrite, membyteread, tx_ready,
        output readdata, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_io.sv
// Data-side memory responder: word RAM plus a memory-mapped I/O page at 0xFFFF_xxxx
// holding a 4-deep transmit FIFO, its status word and a free-running cycle counter.
module dmem_io #(
    parameter int RAM_WORDS = 64
) (
    input  logic       clk,
    input  logic       reset,
    dmem_io_if.slave   bus
);
    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo [4];
    logic [1:0]    rd_ptr;
    logic [1:0]    wr_ptr;
    logic [2:0]    count;
    logic          ovf;
    logic [31:0]   cycles;

    logic          io;
    logic          sel_tx;
    logic          sel_status;
    logic          sel_cycles;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic [AW-1:0] idx;
    logic [31:0]   status;
    logic [31:0]   word;

    assign io         = (bus.addr[31:16] == 16'hFFFF);
    assign sel_tx     = io & (bus.addr[15:0] == 16'h0000);
    assign sel_status = io & (bus.addr[15:0] == 16'h0004);
    assign sel_cycles = io & (bus.addr[15:0] == 16'h0008);
    assign idx        = bus.addr[AW+1:2];

    assign pop      = (count != 3'd0) & bus.tx_ready;
    assign push_req = bus.memwrite & sel_tx;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign push_ok  = push_req & ((count != 3'd4) | pop);

    assign status = {15'b0, ovf, 6'b0, (count == 3'd0), (count == 3'd4), 5'b0, count};

    always_comb begin
        word = 32'h0;
        if (io) begin
            if (sel_status)      word = status;
            else if (sel_cycles) word = cycles;
        end else begin
            word = ram[idx];
        end
    end

    always_comb begin
        bus.readdata = word;
        if (bus.membyteread) begin
            case (bus.addr[1:0])
                2'd0:    bus.readdata = {{24{word[31]}}, word[31:24]};
                2'd1:    bus.readdata = {{24{word[23]}}, word[23:16]};
                2'd2:    bus.readdata = {{24{word[15]}}, word[15:8]};
                default: bus.readdata = {{24{word[7]}},  word[7:0]};
            endcase
        end
    end

    assign bus.tx_data  = fifo[rd_ptr];
    assign bus.tx_valid = (count != 3'd0);

    // Storage arrays carry no reset; RAM keeps accepting writes during reset.
    always_ff @(posedge clk) begin
        if (bus.memwrite & ~io)
            ram[idx] <= bus.writedata;
        if (push_ok)
            fifo[wr_ptr] <= bus.writedata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
            ovf    <= 1'b0;
            cycles <= 32'h0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (push_req & ~push_ok)
                ovf <= 1'b1;
            else if (bus.memwrite & sel_status)
                ovf <= 1'b0;
            if (bus.memwrite & sel_cycles)
                cycles <= bus.writedata;
            else
                cycles <= cycles + 32'd1;
        end
    end
endmodule
